// File: rtl/ball_motion.sv
// Ball kinematics for the brick game: reflects the sign-magnitude velocity,
// advances the ball once per game tick, and runs serve/play/over with lives.
module ball_motion #(
  parameter int SCREEN_W    = 160,
  parameter int SCREEN_H    = 120,
  parameter int TICK_DIV    = 833333,
  parameter int START_LIVES = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       launch,
  input  logic [7:0] paddleX,
  input  logic [7:0] paddleY,
  input  logic [4:0] length,
  input  logic       cX,
  input  logic       cY,
  input  logic       cBrickX,
  input  logic       cBrickY,
  output logic [7:0] ballX,
  output logic [7:0] ballY,
  output logic [2:0] vX,
  output logic [2:0] vY,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       tick
);

  localparam int                CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0]     L_LAST   = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]     L_PRE    = CW'(TICK_DIV - 2);
  localparam logic signed [9:0] L_XMAX   = 10'(SCREEN_W - 1);
  localparam logic [8:0]        L_XMAX9  = 9'(SCREEN_W - 1);
  localparam logic [9:0]        L_YLOSS  = 10'(SCREEN_H - 1);
  localparam logic [1:0]        L_LIVES  = 2'(START_LIVES);
  localparam logic [2:0]        L_VX0    = 3'b001;
  localparam logic [2:0]        L_VY0    = 3'b101;

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_OVER = 2'd2} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_tick;
  logic [7:0]     r_x;
  logic [7:0]     r_y;
  logic [2:0]     r_vx;
  logic [2:0]     r_vy;
  logic [1:0]     r_lives;
  logic           r_over;

  logic [2:0]        w_vx;
  logic [2:0]        w_vy;
  logic signed [9:0] w_x_sum;
  logic signed [9:0] w_y_sum;
  logic [7:0]        w_x_new;
  logic [7:0]        w_y_new;
  logic              w_loss;
  logic [4:0]        w_half;
  logic [8:0]        w_serve_sum;
  logic [7:0]        w_serve_x;
  logic [7:0]        w_serve_y;

  // Reflection happens before the move so the step uses the new direction.
  assign w_vx = {r_vx[2] ^ (cX | cBrickX), r_vx[1:0]};
  assign w_vy = {r_vy[2] ^ (cY | cBrickY), r_vy[1:0]};

  assign w_x_sum = w_vx[2] ? $signed({2'b00, r_x} - {8'd0, w_vx[1:0]})
                           : $signed({2'b00, r_x} + {8'd0, w_vx[1:0]});
  assign w_y_sum = w_vy[2] ? $signed({2'b00, r_y} - {8'd0, w_vy[1:0]})
                           : $signed({2'b00, r_y} + {8'd0, w_vy[1:0]});

  assign w_x_new = (w_x_sum < 10'sd0)  ? 8'd0 :
                   (w_x_sum > L_XMAX)  ? L_XMAX[7:0] : w_x_sum[7:0];
  // Downward overflow is impossible here: it would already count as a loss.
  assign w_y_new = (w_y_sum < 10'sd0)  ? 8'd0 : w_y_sum[7:0];

  assign w_loss = ~w_vy[2] && (({2'b00, r_y} + {8'd0, w_vy[1:0]}) >= L_YLOSS);

  assign w_half      = length >> 1;
  assign w_serve_sum = {1'b0, paddleX} + {4'd0, w_half};
  assign w_serve_x   = (w_serve_sum > L_XMAX9) ? L_XMAX9[7:0] : w_serve_sum[7:0];
  assign w_serve_y   = (paddleY == 8'd0) ? 8'd0 : (paddleY - 8'd1);

  // Tick divider plus the serve/play/over machine; all game state moves only on tick.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_SERVE;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_x     <= 8'd0;
      r_y     <= 8'd0;
      r_vx    <= L_VX0;
      r_vy    <= L_VY0;
      r_lives <= L_LIVES;
      r_over  <= 1'b0;
    end else begin
      if (r_cnt == L_LAST) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Registered strobe lines up with the cycle the counter sits at its last value.
      r_tick <= (r_cnt == L_PRE);

      if (r_tick) begin
        case (r_state)
          S_SERVE: begin
            r_x  <= w_serve_x;
            r_y  <= w_serve_y;
            r_vx <= L_VX0;
            r_vy <= L_VY0;
            if (launch) begin
              r_state <= S_PLAY;
            end else begin
              r_state <= S_SERVE;
            end
          end
          S_PLAY: begin
            r_vx <= w_vx;
            r_vy <= w_vy;
            if (w_loss) begin
              if (r_lives <= 2'd1) begin
                r_lives <= 2'd0;
                r_over  <= 1'b1;
                r_state <= S_OVER;
              end else begin
                r_lives <= r_lives - 2'd1;
                r_state <= S_SERVE;
              end
            end else begin
              r_x <= w_x_new;
              r_y <= w_y_new;
            end
          end
          S_OVER: begin
            if (launch) begin
              r_lives <= L_LIVES;
              r_over  <= 1'b0;
              r_state <= S_SERVE;
            end else begin
              r_state <= S_OVER;
            end
          end
          default: begin
            r_state <= S_SERVE;
          end
        endcase
      end
    end
  end

  assign ballX     = r_x;
  assign ballY     = r_y;
  assign vX        = r_vx;
  assign vY        = r_vy;
  assign lives     = r_lives;
  assign game_over = r_over;
  assign tick      = r_tick;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion with a short tick divider: a vector table for
// the main play path plus hand sequences for walls, roof, loss, over and reset.
module tb_ball_motion;

  logic       clock = 1'b0;
  logic       reset;
  logic       launch;
  logic [7:0] paddleX, paddleY;
  logic [4:0] length;
  logic       cX, cY, cBrickX, cBrickY;
  logic [7:0] ballX, ballY;
  logic [2:0] vX, vY;
  logic [1:0] lives;
  logic       game_over, tick;

  int checks = 0;
  int errors = 0;

  ball_motion #(.SCREEN_W(160), .SCREEN_H(120), .TICK_DIV(4), .START_LIVES(3)) dut (
    .clock(clock), .reset(reset), .launch(launch),
    .paddleX(paddleX), .paddleY(paddleY), .length(length),
    .cX(cX), .cY(cY), .cBrickX(cBrickX), .cBrickY(cBrickY),
    .ballX(ballX), .ballY(ballY), .vX(vX), .vY(vY),
    .lives(lives), .game_over(game_over), .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       l;
    logic [7:0] px, py;
    logic [4:0] len;
    logic [3:0] col;   // {cX, cY, cBrickX, cBrickY}
    logic [7:0] ex, ey;
    logic [2:0] evx, evy;
    logic [1:0] el;
    logic       eg;
  } vec_t;

  vec_t tbl[8];

  task automatic check_out(input string nm, input logic [7:0] ex, ey,
                           input logic [2:0] evx, evy, input logic [1:0] el, input logic eg);
    checks++;
    if ({ballX, ballY, vX, vY, lives, game_over} !== {ex, ey, evx, evy, el, eg}) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d vx=%b vy=%b lives=%0d go=%b, want x=%0d y=%0d vx=%b vy=%b lives=%0d go=%b",
               nm, ballX, ballY, vX, vY, lives, game_over, ex, ey, evx, evy, el, eg);
    end
  endtask

  task automatic check_tick(input string nm, input int k, input logic exp);
    checks++;
    if (tick !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: tick=%b want %b", nm, k, tick, exp);
    end
  endtask

  // Drive inputs, wait (bounded) for the tick cycle, then check outputs after the update edge.
  task automatic step(input string nm, input logic l, input logic [7:0] px, py,
                      input logic [4:0] len, input logic [3:0] col,
                      input logic [7:0] ex, ey, input logic [2:0] evx, evy,
                      input logic [1:0] el, input logic eg);
    int n;
    launch = l; paddleX = px; paddleY = py; length = len;
    {cX, cY, cBrickX, cBrickY} = col;
    n = 0;
    while (tick !== 1'b1 && n < 16) begin
      @(negedge clock);
      n++;
    end
    if (tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: tick timeout, tick=%b want 1", nm, tick);
    end else begin
      @(posedge clock);
      @(negedge clock);
      check_out(nm, ex, ey, evx, evy, el, eg);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clock);
    reset = 1'b0; launch = 1'b0;
    {cX, cY, cBrickX, cBrickY} = 4'b0000;
    @(posedge clock);
    @(negedge clock);
    check_out(nm, 8'd0, 8'd0, 3'b001, 3'b101, 2'd3, 1'b0);
    check_tick(nm, 0, 1'b0);
    reset = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Main play path: serve, launch, move, and every reflection combination.
    tbl[0] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b0000, 8'd78, 8'd109, 3'b001, 3'b101, 2'd3, 1'b0};
    tbl[1] = '{1'b1, 8'd70, 8'd110, 5'd16, 4'b0000, 8'd78, 8'd109, 3'b001, 3'b101, 2'd3, 1'b0};
    tbl[2] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b0000, 8'd79, 8'd108, 3'b001, 3'b101, 2'd3, 1'b0};
    tbl[3] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b0000, 8'd80, 8'd107, 3'b001, 3'b101, 2'd3, 1'b0};
    tbl[4] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b0010, 8'd79, 8'd106, 3'b101, 3'b101, 2'd3, 1'b0};
    tbl[5] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b0100, 8'd78, 8'd107, 3'b101, 3'b001, 2'd3, 1'b0};
    tbl[6] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b1001, 8'd79, 8'd106, 3'b001, 3'b101, 2'd3, 1'b0};
    tbl[7] = '{1'b0, 8'd70, 8'd110, 5'd16, 4'b1100, 8'd78, 8'd107, 3'b101, 3'b001, 2'd3, 1'b0};

    reset = 1'b0; launch = 1'b0;
    paddleX = 8'd70; paddleY = 8'd110; length = 5'd16;
    {cX, cY, cBrickX, cBrickY} = 4'b0000;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check_out("reset", 8'd0, 8'd0, 3'b001, 3'b101, 2'd3, 1'b0);
    check_tick("reset_tick", 0, 1'b0);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      @(negedge clock);
      check_tick("tick_period", k, (k % 4) == 3);
    end
    check_out("serve_idle", 8'd78, 8'd109, 3'b001, 3'b101, 2'd3, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step($sformatf("table_%0d", i), tbl[i].l, tbl[i].px, tbl[i].py, tbl[i].len, tbl[i].col,
           tbl[i].ex, tbl[i].ey, tbl[i].evx, tbl[i].evy, tbl[i].el, tbl[i].eg);
    end

    // Right wall: serve saturation, x clamp at 159, then wall bounce.
    do_reset("reset_b");
    step("serve_sat",   1'b0, 8'd200, 8'd50, 5'd20, 4'b0000, 8'd159, 8'd49, 3'b001, 3'b101, 2'd3, 1'b0);
    step("launch_b",    1'b1, 8'd158, 8'd50, 5'd0,  4'b0000, 8'd158, 8'd49, 3'b001, 3'b101, 2'd3, 1'b0);
    step("to_wall",     1'b0, 8'd158, 8'd50, 5'd0,  4'b0000, 8'd159, 8'd48, 3'b001, 3'b101, 2'd3, 1'b0);
    step("x_clamp_hi",  1'b0, 8'd158, 8'd50, 5'd0,  4'b0000, 8'd159, 8'd47, 3'b001, 3'b101, 2'd3, 1'b0);
    step("wall_bounce", 1'b0, 8'd158, 8'd50, 5'd0,  4'b1000, 8'd158, 8'd46, 3'b101, 3'b101, 2'd3, 1'b0);
    step("both_flip",   1'b0, 8'd158, 8'd50, 5'd0,  4'b1001, 8'd159, 8'd47, 3'b001, 3'b001, 2'd3, 1'b0);

    // Roof and left wall clamps, paddleY of zero.
    do_reset("reset_c");
    step("serve_py0",   1'b0, 8'd0, 8'd0, 5'd0, 4'b0000, 8'd0, 8'd0, 3'b001, 3'b101, 2'd3, 1'b0);
    step("launch_c",    1'b1, 8'd0, 8'd1, 5'd0, 4'b0000, 8'd0, 8'd0, 3'b001, 3'b101, 2'd3, 1'b0);
    step("corner",      1'b0, 8'd0, 8'd1, 5'd0, 4'b1000, 8'd0, 8'd0, 3'b101, 3'b101, 2'd3, 1'b0);
    step("roof_bounce", 1'b0, 8'd0, 8'd1, 5'd0, 4'b0100, 8'd0, 8'd1, 3'b101, 3'b001, 2'd3, 1'b0);
    step("roof_up",     1'b0, 8'd0, 8'd1, 5'd0, 4'b0100, 8'd0, 8'd0, 3'b101, 3'b101, 2'd3, 1'b0);
    step("y_clamp_lo",  1'b0, 8'd0, 8'd1, 5'd0, 4'b0000, 8'd0, 8'd0, 3'b101, 3'b101, 2'd3, 1'b0);

    // Paddle hit at the bottom, three losses, game over hold, restart.
    do_reset("reset_d");
    step("serve_low",   1'b0, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd78, 8'd118, 3'b001, 3'b101, 2'd3, 1'b0);
    step("launch_d",    1'b1, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd78, 8'd118, 3'b001, 3'b101, 2'd3, 1'b0);
    step("rise",        1'b0, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd79, 8'd117, 3'b001, 3'b101, 2'd3, 1'b0);
    step("drop",        1'b0, 8'd70, 8'd119, 5'd16, 4'b0100, 8'd80, 8'd118, 3'b001, 3'b001, 2'd3, 1'b0);
    step("paddle_hit",  1'b0, 8'd70, 8'd119, 5'd16, 4'b0100, 8'd81, 8'd117, 3'b001, 3'b101, 2'd3, 1'b0);
    step("drop2",       1'b0, 8'd70, 8'd119, 5'd16, 4'b0100, 8'd82, 8'd118, 3'b001, 3'b001, 2'd3, 1'b0);
    step("loss1",       1'b0, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd82, 8'd118, 3'b001, 3'b001, 2'd2, 1'b0);
    step("rehome",      1'b0, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd78, 8'd118, 3'b001, 3'b101, 2'd2, 1'b0);
    step("launch_d2",   1'b1, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd78, 8'd118, 3'b001, 3'b101, 2'd2, 1'b0);
    step("loss2",       1'b0, 8'd70, 8'd119, 5'd16, 4'b0100, 8'd78, 8'd118, 3'b001, 3'b001, 2'd1, 1'b0);
    step("launch_d3",   1'b1, 8'd70, 8'd119, 5'd16, 4'b0000, 8'd78, 8'd118, 3'b001, 3'b101, 2'd1, 1'b0);
    step("loss3_over",  1'b0, 8'd70, 8'd119, 5'd16, 4'b0100, 8'd78, 8'd118, 3'b001, 3'b001, 2'd0, 1'b1);
    step("over_hold",   1'b0, 8'd10, 8'd119, 5'd4,  4'b1111, 8'd78, 8'd118, 3'b001, 3'b001, 2'd0, 1'b1);
    step("restart",     1'b1, 8'd10, 8'd119, 5'd4,  4'b0000, 8'd78, 8'd118, 3'b001, 3'b001, 2'd3, 1'b0);
    step("serve_after", 1'b0, 8'd10, 8'd119, 5'd4,  4'b0000, 8'd12, 8'd118, 3'b001, 3'b101, 2'd3, 1'b0);

    // Collisions between ticks are ignored; then reset lands mid-tick.
    do_reset("reset_e");
    step("launch_e",    1'b1, 8'd70, 8'd110, 5'd16, 4'b0000, 8'd78, 8'd109, 3'b001, 3'b101, 2'd3, 1'b0);
    launch = 1'b0;
    {cX, cY, cBrickX, cBrickY} = 4'b1111;
    @(negedge clock);
    @(negedge clock);
    {cX, cY, cBrickX, cBrickY} = 4'b0000;
    step("off_tick_col", 1'b0, 8'd70, 8'd110, 5'd16, 4'b0000, 8'd79, 8'd108, 3'b001, 3'b101, 2'd3, 1'b0);
    do_reset("reset_mid");
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      check_tick("tick_after_reset", k, k == 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
